// File: rtl/sd_crc16_multi_pkg.sv
// Shared types, constants and the CRC-16 bit-step helper for the multi-lane SD CRC engine.
package sd_crc_pkg;

    localparam int unsigned CRC_W = 16;
    localparam logic [CRC_W-1:0] CRC16_CCITT_POLY = 16'h1021;

    typedef enum logic [1:0] {IDLE, DATA, TAIL, FIN} sd_crc_state_t;
    typedef logic [CRC_W-1:0] crc16_t;

    // Per-lane register command, decoded once by the FSM and broadcast to every lane
    typedef struct packed {
        logic clr;
        logic upd;
        logic shift;
    } lane_ctrl_t;

    function automatic crc16_t crc16_step(input crc16_t crc, input logic din, input crc16_t poly);
        crc16_t nxt;
        nxt = {crc[CRC_W-2:0], 1'b0};
        if (din ^ crc[CRC_W-1]) begin
            nxt = nxt ^ poly;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/sd_crc16_multi_if.sv
// Block-control and data-path bus of sd_crc16_multi.
// Optional ERR_CNT signal present only when SD_CRC_ERR_CNT_EN is defined.
interface sd_crc16_multi_if #(
    parameter int unsigned LANES = 4
);
    logic                  START;
    logic                  MODE;
    logic                  ABORT;
    logic                  ENABLE;
    logic [LANES-1:0]      DIN;
    logic [LANES-1:0]      CRC_OUT;
    logic                  CRC_OUT_VALID;
    logic                  BUSY;
    logic                  DONE;
    logic [LANES-1:0]      CRC_ERR;
    logic [LANES*16-1:0]   CRC;
`ifdef SD_CRC_ERR_CNT_EN
    logic [7:0]            ERR_CNT;
`endif

    modport slave (
        input  START, MODE, ABORT, ENABLE, DIN,
`ifdef SD_CRC_ERR_CNT_EN
        output ERR_CNT,
`endif
        output CRC_OUT, CRC_OUT_VALID, BUSY, DONE, CRC_ERR, CRC
    );

    modport master (
        output START, MODE, ABORT, ENABLE, DIN,
`ifdef SD_CRC_ERR_CNT_EN
        input  ERR_CNT,
`endif
        input  CRC_OUT, CRC_OUT_VALID, BUSY, DONE, CRC_ERR, CRC
    );

endinterface

// File: rtl/sd_crc16_multi_lane.sv
// One DAT lane's CRC-16 register: clear, absorb one bit, or shift out zero-filled.
module sd_crc16_lane
    import sd_crc_pkg::*;
#(
    parameter crc16_t POLY = CRC16_CCITT_POLY
) (
    input  logic       CLK,
    input  logic       RST,
    input  lane_ctrl_t ctrl_i,
    input  logic       din_i,
    output crc16_t     crc_o
);

    crc16_t crc_q;
    crc16_t crc_d;

    always_comb begin
        crc_d = crc_q;
        if (ctrl_i.clr) begin
            crc_d = '0;
        end else if (ctrl_i.upd) begin
            crc_d = crc16_step(crc_q, din_i, POLY);
        end else if (ctrl_i.shift) begin
            crc_d = {crc_q[CRC_W-2:0], 1'b0};
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            crc_q <= '0;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc_o = crc_q;

endmodule

// File: rtl/sd_crc16_multi.sv
// Multi-lane block-framed CRC-16 engine: generate (shift CRC out) or check (residue) per block.
// Optional error counter output enabled by defining SD_CRC_ERR_CNT_EN.
module sd_crc16_multi
    import sd_crc_pkg::*;
#(
    parameter int unsigned LANES   = 4,
    parameter int unsigned BLK_LEN = 1024,
    parameter crc16_t      POLY    = CRC16_CCITT_POLY
) (
    input  logic              CLK,
    input  logic              RST,
    sd_crc16_multi_if.slave   bus
);

    // The tail phase counts to 15, so the counter never drops below 4 bits
    localparam int unsigned CNT_RAW   = $clog2(BLK_LEN + 1);
    localparam int unsigned CNT_W     = (CNT_RAW > 4) ? CNT_RAW : 4;
    localparam int unsigned TAIL_LAST = CRC_W - 1;

    sd_crc_state_t        state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 mode_q, mode_d;
    logic [LANES-1:0]     err_q, err_d;
    logic                 busy_q, done_q, valid_q;
    lane_ctrl_t           ctrl;
    logic [LANES*CRC_W-1:0] crc_w;
    logic [LANES-1:0]     msb_w;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        sd_crc16_lane #(.POLY(POLY)) u_lane (
            .CLK    (CLK),
            .RST    (RST),
            .ctrl_i (ctrl),
            .din_i  (bus.DIN[g]),
            .crc_o  (crc_w[g*CRC_W +: CRC_W])
        );
        assign msb_w[g] = crc_w[g*CRC_W + CRC_W - 1];
    end

    // Next-state, counter and lane command decode; ABORT overrides everything
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        err_d   = err_q;
        ctrl    = '0;

        if (bus.ABORT) begin
            state_d = IDLE;
            cnt_d   = '0;
            err_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.START) begin
                        mode_d   = bus.MODE;
                        ctrl.clr = 1'b1;
                        cnt_d    = '0;
                        err_d    = '0;
                        state_d  = DATA;
                    end
                end
                DATA: begin
                    if (bus.ENABLE) begin
                        ctrl.upd = 1'b1;
                        if (cnt_q == CNT_W'(BLK_LEN - 1)) begin
                            cnt_d   = '0;
                            state_d = TAIL;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                TAIL: begin
                    if (bus.ENABLE) begin
                        ctrl.upd   = mode_q;
                        ctrl.shift = ~mode_q;
                        if (cnt_q == CNT_W'(TAIL_LAST)) begin
                            cnt_d   = '0;
                            state_d = FIN;
                            // Residue after absorbing the received CRC must be zero
                            if (mode_q) begin
                                for (int i = 0; i < LANES; i++) begin
                                    err_d[i] = (crc16_step(crc_w[i*CRC_W +: CRC_W],
                                                           bus.DIN[i], POLY) != '0);
                                end
                            end
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                FIN: begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end
                default: begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Status outputs are registered from the next state so they align with state_q
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt_q   <= '0;
            mode_q  <= 1'b0;
            err_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            err_q   <= err_d;
            busy_q  <= (state_d == DATA) || (state_d == TAIL);
            done_q  <= (state_d == FIN);
            valid_q <= (state_d == TAIL) && !mode_d;
        end
    end

`ifdef SD_CRC_ERR_CNT_EN
    logic [7:0] err_cnt_q;

    // Saturating count of failed check-mode blocks; only RST clears it
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            err_cnt_q <= '0;
        end else if ((state_q == FIN) && mode_q && (|err_q) && (err_cnt_q != 8'hFF)) begin
            err_cnt_q <= err_cnt_q + 8'(1);
        end
    end

    assign bus.ERR_CNT = err_cnt_q;
`endif

    assign bus.CRC_OUT       = valid_q ? msb_w : '0;
    assign bus.CRC_OUT_VALID = valid_q;
    assign bus.BUSY          = busy_q;
    assign bus.DONE          = done_q;
    assign bus.CRC_ERR       = err_q;
    assign bus.CRC           = crc_w;

endmodule

// File: tb/tb_sd_crc16_multi.sv
// Directed/randomized bench for sd_crc16_multi; reference CRC computed by polynomial long division.
module tb_sd_crc16_multi;

    localparam int unsigned LANES = 4;
    localparam int unsigned BLK   = 64;
    localparam int unsigned TOT   = BLK + 16;

    typedef logic bitq_t[$];

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    logic [LANES-1:0]    dat [TOT];
    logic [15:0]         cap [LANES];
    logic [LANES*16-1:0] hold_crc;
    int                  exp_cnt = 0;

    sd_crc16_multi_if #(.LANES(LANES)) bus ();

    sd_crc16_multi #(.LANES(LANES), .BLK_LEN(BLK), .POLY(16'h1021)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Remainder of M(x)*x^16 divided by x^16+x^12+x^5+1
    function automatic logic [15:0] crc_div(input bitq_t q);
        logic [16:0] rem;
        rem = '0;
        for (int k = 0; k < q.size() + 16; k++) begin
            rem = {rem[15:0], (k < q.size()) ? q[k] : 1'b0};
            if (rem[16]) rem = rem ^ 17'h11021;
        end
        return rem[15:0];
    endfunction

    function automatic bitq_t lane_bits(input int lane, input int lo, input int n);
        bitq_t q;
        for (int k = lo; k < lo + n; k++) q.push_back(dat[k][lane]);
        return q;
    endfunction

    function automatic bitq_t val_bits(input logic [15:0] v);
        bitq_t q;
        for (int k = 15; k >= 0; k--) q.push_back(v[k]);
        return q;
    endfunction

    task automatic fill(input int kind);
        for (int k = 0; k < TOT; k++)
            dat[k] = (kind == 0) ? '1 : (kind == 1) ? '0 : LANES'($urandom);
    endtask

    // One full block; data/tail bits come from dat[], ENABLE is high with probability en_pct
    task automatic run_block(input logic mode, input int en_pct, input bit start_mid,
                             input bit start_fin, input string tag);
        logic [15:0]         r, c;
        logic [LANES-1:0]    exp_err;
        logic [LANES*16-1:0] exp_tail, exp_fin;
        int idx, idles, ticks, first_done;
        bit en, tail_seen;

        exp_err = '0;
        for (int i = 0; i < LANES; i++) begin
            r = crc_div(lane_bits(i, 0, BLK));
            for (int k = 0; k < 16; k++) c[15-k] = dat[BLK+k][i];
            exp_err[i] = mode && (c != r);
            exp_tail[i*16 +: 16] = r;
            exp_fin[i*16 +: 16]  = mode ? crc_div(val_bits(r ^ c)) : 16'h0;
        end

        bus.START = 1'b1; bus.MODE = mode; bus.ENABLE = 1'b1; bus.DIN = LANES'($urandom);
        tick();
        bus.START = 1'b0; bus.MODE = ~mode;
        chk({tag, "_busy_start"}, 64'(bus.BUSY), 64'd1);

        idx = 0; idles = 0; ticks = 1; first_done = -1; tail_seen = 0;
        while (idx < TOT && ticks < 20 * TOT) begin
            en = ($urandom_range(99) < en_pct);
            bus.ENABLE = en;
            bus.DIN    = en ? dat[idx] : LANES'($urandom);
            bus.START  = start_mid && (idx == BLK / 2);
            if (idx >= BLK) begin
                if (idx == BLK && !tail_seen) begin
                    tail_seen = 1;
                    chk({tag, "_out_valid"}, 64'(bus.CRC_OUT_VALID), 64'(!mode));
                    if (mode) chk({tag, "_out_zero"}, 64'(bus.CRC_OUT), 64'd0);
                end
                if (!mode && en)
                    for (int i = 0; i < LANES; i++) cap[i][15-(idx-BLK)] = bus.CRC_OUT[i];
            end
            tick();
            ticks++;
            if (en) idx++; else idles++;
            if (idx == BLK && !tail_seen && en)
                chk({tag, "_crc_tail"}, 64'(bus.CRC), 64'(exp_tail));
            if (bus.DONE && first_done < 0) first_done = ticks;
        end
        bus.START = 1'b0; bus.ENABLE = 1'b0;

        chk({tag, "_done_lat"}, 64'(first_done), 64'(1 + TOT + idles));
        chk({tag, "_busy_fin"}, 64'(bus.BUSY), 64'd0);
        chk({tag, "_crc_err"}, 64'(bus.CRC_ERR), 64'(exp_err));
        chk({tag, "_crc_fin"}, 64'(bus.CRC), 64'(exp_fin));
        if (!mode)
            for (int i = 0; i < LANES; i++)
                chk($sformatf("%s_serial%0d", tag, i), 64'(cap[i]), 64'(exp_tail[i*16 +: 16]));
        if (mode && exp_err != '0 && exp_cnt < 255) exp_cnt++;

        bus.START = start_fin;
        tick();
        bus.START = 1'b0;
        chk({tag, "_done_pulse"}, 64'({bus.DONE, bus.BUSY}), 64'd0);
        chk({tag, "_err_hold"}, 64'(bus.CRC_ERR), 64'(exp_err));
`ifdef SD_CRC_ERR_CNT_EN
        chk({tag, "_err_cnt"}, 64'(bus.ERR_CNT), 64'(exp_cnt));
`endif
        hold_crc = exp_fin;
    endtask

    initial begin
        logic [LANES*16-1:0] pre;
        int done_cnt;

        rst = 1'b1;
        bus.START = 0; bus.MODE = 0; bus.ABORT = 0; bus.ENABLE = 0; bus.DIN = '0;
        tick(); tick();
        chk("rst_crc", 64'(bus.CRC), 64'd0);
        chk("rst_flags", 64'({bus.BUSY, bus.DONE, bus.CRC_OUT_VALID}), 64'd0);
        chk("rst_vec", 64'({bus.CRC_ERR, bus.CRC_OUT}), 64'd0);
        rst = 1'b0;
        tick();

        fill(0); run_block(1'b0, 100, 0, 0, "gen_ones");
        fill(2); run_block(1'b0, 100, 0, 0, "gen_rand");

        // Loop generated CRC back with the same data, ENABLE toggled
        for (int k = 0; k < 16; k++)
            for (int i = 0; i < LANES; i++) dat[BLK+k][i] = cap[i][15-k];
        run_block(1'b1, 50, 0, 0, "loopback");

        fill(1); run_block(1'b1, 100, 0, 0, "chk_zero");
        dat[BLK+8][2] = 1'b1;
        run_block(1'b1, 100, 0, 1, "chk_flip");

        // Abort mid-block with ENABLE high: CRC holds, error cleared, no DONE
        fill(2);
        bus.START = 1'b1; bus.MODE = 1'b0; tick(); bus.START = 1'b0;
        bus.ENABLE = 1'b1;
        for (int k = 0; k < 30; k++) begin bus.DIN = dat[k]; tick(); end
        bus.ABORT = 1'b1; bus.DIN = dat[30];
        tick();
        bus.ABORT = 1'b0; bus.ENABLE = 1'b0;
        for (int i = 0; i < LANES; i++) pre[i*16 +: 16] = crc_div(lane_bits(i, 0, 30));
        chk("abort_busy", 64'(bus.BUSY), 64'd0);
        chk("abort_err", 64'(bus.CRC_ERR), 64'd0);
        chk("abort_crc", 64'(bus.CRC), 64'(pre));
        done_cnt = 0;
        for (int k = 0; k < 5; k++) begin
            if (bus.DONE) done_cnt++;
            tick();
        end
        chk("abort_nodone", 64'(done_cnt), 64'd0);

        bus.ABORT = 1'b1; bus.START = 1'b1; tick();
        bus.ABORT = 1'b0; bus.START = 1'b0; tick();
        chk("abort_start_busy", 64'(bus.BUSY), 64'd0);
        chk("abort_start_crc", 64'(bus.CRC), 64'(pre));

        fill(2); run_block(1'b0, 70, 1, 0, "after_abort");
        fill(2); run_block(1'b1, 80, 0, 0, "chk_rand");
        fill(2); run_block(1'b1, 100, 1, 1, "chk_rand2");

        // Asynchronous reset in the middle of the tail
        fill(2);
        bus.START = 1'b1; bus.MODE = 1'b0; tick(); bus.START = 1'b0;
        bus.ENABLE = 1'b1;
        for (int k = 0; k < BLK + 5; k++) begin bus.DIN = dat[k]; tick(); end
        chk("pre_rst_valid", 64'(bus.CRC_OUT_VALID), 64'd1);
        #1 rst = 1'b1;
        #1;
        chk("rst_tail_crc", 64'(bus.CRC), 64'd0);
        chk("rst_tail_flags", 64'({bus.BUSY, bus.DONE, bus.CRC_OUT_VALID, bus.CRC_OUT}), 64'd0);
        exp_cnt = 0;
`ifdef SD_CRC_ERR_CNT_EN
        chk("rst_err_cnt", 64'(bus.ERR_CNT), 64'd0);
`endif
        bus.ENABLE = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        fill(2); run_block(1'b0, 100, 0, 0, "post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sd_crc16_multi.md
Name: sd_crc16_multi

Overview:
Multi-lane, block-framed CRC-16 engine for the SD data path. It runs one CRC-16 (CCITT, x^16+x^12+x^5+1, init 0) per DAT lane over a fixed-length block. In generate mode it then shifts the 16 CRC bits out on each lane. In check mode it absorbs the received 16 CRC bits and flags per-lane mismatches. It sits between the SD data serializer/deserializer and the block controller, and replaces the single-lane, free-running CRC-16 register.

Parameters:
LANES, 4, number of DAT lanes (1, 4 or 8); each lane has an independent CRC.
BLK_LEN, 1024, data bits per lane per block (512-byte block on 4 lanes); must be >= 1.
POLY, 16'h1021, feedback polynomial (bit 16 implicit).

Ports:
CLK  in  1  clock
RST  in  1  reset
START  in  1  pulse; begins a block (accepted in IDLE only)
MODE  in  1  sampled with START: 0 = generate, 1 = check
ABORT  in  1  synchronous abort to IDLE
ENABLE  in  1  bit-valid strobe; one bit per lane consumed per enabled cycle
DIN  in  LANES  data bit per lane (in check mode, also the received CRC bits)
CRC_OUT  out  LANES  generate mode: current CRC MSB per lane during TAIL
CRC_OUT_VALID  out  1  high in TAIL when mode = generate
BUSY  out  1  high in DATA and TAIL
DONE  out  1  one-cycle pulse at block completion
CRC_ERR  out  LANES  per-lane mismatch, valid from DONE until the next START
CRC  out  LANES*16  live CRC registers; lane i occupies bits [16i+15:16i]

Behaviour:
- Reset (RST, asynchronous, active-high; clock CLK): state IDLE. All CRC registers, counters, CRC_ERR, DONE, BUSY, CRC_OUT and CRC_OUT_VALID go to 0.
- States: IDLE -> DATA -> TAIL -> FIN -> IDLE.
- IDLE:
  - START=1 latches MODE, clears all CRC registers, bit counter and CRC_ERR, then goes to DATA.
  - ENABLE in the same cycle as START is ignored. The first data bit is taken on the following enabled cycle.
- DATA: on each ENABLE=1 cycle, per lane: inv = DIN[i] ^ crc[15]; crc <= {crc[14:0],1'b0} ^ (inv ? POLY : 0). When the BLK_LEN-th enabled bit is consumed, reset the counter and go to TAIL. ENABLE=0 holds all state.
- TAIL, 16 enabled cycles:
  - Generate mode: CRC_OUT[i] = crc_i[15] combinationally. On each enabled cycle, crc_i <= crc_i << 1, zero-filled. After 16 shifts every register is 0.
  - Check mode: DIN is fed through the same update as in DATA. After the 16th bit, CRC_ERR[i] <= (crc_i != 0), the residue check.
  - The 16th enabled bit moves the FSM to FIN.
- FIN: DONE=1 for exactly one cycle, then IDLE. CRC_ERR holds its value until the next accepted START.
- START while BUSY or in FIN is ignored. ABORT has priority over everything except RST: from any state it goes to IDLE with no DONE pulse; CRC registers hold, CRC_ERR is cleared. ABORT and START together in IDLE: ABORT wins and the block is not started.
- Counter width: $clog2(BLK_LEN+1). It wraps to 0 on each state change.
- MODE changes after START have no effect.
- Latency: DONE is asserted exactly BLK_LEN+16 enabled cycles after START, plus 1 cycle.

Optional Feature:
SD_CRC_ERR_CNT_EN:
- When defined: adds output ERR_CNT [7:0], which increments on each FIN where |CRC_ERR is true in check mode. It saturates at 8'hFF and is cleared only by RST.
- When not defined: the port and its logic are absent.

Decomposition:
- Package sd_crc_pkg holds: CRC_W=16; CRC16_CCITT_POLY=16'h1021; typedef enum logic [1:0] {IDLE, DATA, TAIL, FIN} sd_crc_state_t; typedef logic [CRC_W-1:0] crc16_t.
- Sub-module sd_crc16_lane: one lane's register with clear, update(bit) and shift inputs. It is instantiated LANES times through a generate loop. The top level holds the FSM, counters and error aggregation.

Test Plan:
- LANES=1, BLK_LEN=4096, generate mode, DIN=1 for all bits -> CRC=16'h7FA1 entering TAIL; CRC_OUT then serialises 0,1,1,1,1,1,1,1,1,0,1,0,0,0,0,1; DONE occurs exactly 4113 cycles after START with ENABLE tied high.
- LANES=4, check mode, all-zero data followed by a zero CRC on each lane -> CRC_ERR=4'b0000 and a DONE pulse. Repeat with lane 2 CRC bit 7 flipped -> CRC_ERR=4'b0100.
- Generate a block with random data, loop CRC_OUT back through a second run in check mode with the same data -> CRC_ERR=0 on every lane.
- ENABLE toggled 50% in DATA and TAIL -> CRC identical to the ENABLE-high run; DONE is delayed by exactly the number of idle cycles.
- ABORT at bit 500, then START again -> no DONE for the aborted block, BUSY drops the next cycle, and the new block result is correct. START asserted mid-block is ignored.
- RST asserted mid-TAIL -> all outputs 0 immediately (asynchronous). With SD_CRC_ERR_CNT_EN defined: 3 erroneous blocks -> ERR_CNT=3; RST -> ERR_CNT=0.
